// File: rtl/posi_fetch.sv
// posi_fetch: gathers the top/top-right/left/left-below/top-left neighbour samples
// of one 4x4 block from the row, column and frame-line RAMs.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif
`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 7
`endif
module posi_fetch #(
  parameter int PIXEL_WIDTH = `PIXEL_WIDTH,
  parameter int PIC_X_WIDTH = `PIC_X_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [3:0]                 blk_4x4_x_i,
  input  logic [3:0]                 blk_4x4_y_i,
  input  logic [PIC_X_WIDTH-1:0]     ctu_x_cur_i,
  input  logic                       ctu_x_first_i,
  input  logic                       ctu_x_last_i,
  input  logic                       ctu_y_first_i,
  output logic                       row_rd_ena_o,
  output logic [7:0]                 row_rd_adr_o,
  input  logic [PIXEL_WIDTH*4-1:0]   row_rd_dat_i,
  output logic                       col_rd_ena_o,
  output logic [7:0]                 col_rd_adr_o,
  input  logic [PIXEL_WIDTH*4-1:0]   col_rd_dat_i,
  output logic                       fra_rd_ena_o,
  output logic [PIC_X_WIDTH+3:0]     fra_rd_adr_o,
  input  logic [PIXEL_WIDTH*4-1:0]   fra_rd_dat_i,
  output logic [PIXEL_WIDTH*8-1:0]   ref_top_o,
  output logic [PIXEL_WIDTH*8-1:0]   ref_lft_o,
  output logic [PIXEL_WIDTH-1:0]     ref_tl_o,
  output logic [4:0]                 avail_o,
  output logic                       done_o
);
  localparam logic [PIXEL_WIDTH*4-1:0] FILL = {4{1'b1, {(PIXEL_WIDTH-1){1'b0}}}};
  typedef enum logic [2:0] {IDLE, RD_T, RD_TR, RD_L, RD_LB, RD_TL, FIN} state_t;
  state_t st, nx;
  logic [3:0] bx, by, bxi, bxd, byi, byd;
  logic [PIC_X_WIDTH-1:0] cx, cxi, cxd;
  logic xf, xl, yf;
  logic av_t, av_tr, av_l, av_lb, av_tl;
  logic row_t, row_tr, row_tl, col_l, col_lb, col_tl, fra_t, fra_tr, fra_tl;
  always_comb begin
    nx = st == IDLE ? (start_i ? RD_T : IDLE) : st == FIN ? IDLE : state_t'(st + 3'd1);
    bxi = bx + 4'd1;
    bxd = bx - 4'd1;
    byi = by + 4'd1;
    byd = by - 4'd1;
    cxi = cx + PIC_X_WIDTH'(1);
    cxd = cx - PIC_X_WIDTH'(1);
    av_t = by != 0 || !yf;
    av_tr = by != 0 ? bx != 15 : !yf && !(bx == 15 && xl);
    av_l = bx != 0 || !xf;
    av_lb = bx == 0 && by != 15 && !xf;
    av_tl = (bx != 0 || !xf) && (by != 0 || !yf);
    row_t = st == RD_T && by != 0;
    row_tr = st == RD_TR && by != 0 && bx != 15;
    row_tl = st == RD_TL && by != 0 && bx != 0;
    col_l = st == RD_L && av_l;
    col_lb = st == RD_LB && av_lb;
    col_tl = st == RD_TL && by != 0 && bx == 0 && !xf;
    fra_t = st == RD_T && by == 0 && !yf;
    fra_tr = st == RD_TR && by == 0 && av_tr;
    fra_tl = st == RD_TL && by == 0 && av_tl;
    row_rd_ena_o = row_t || row_tr || row_tl;
    col_rd_ena_o = col_l || col_lb || col_tl;
    fra_rd_ena_o = fra_t || fra_tr || fra_tl;
    row_rd_adr_o = row_t ? {byd, bx} : row_tr ? {byd, bxi} : row_tl ? {byd, bxd} : 8'd0;
    col_rd_adr_o = col_l ? {bxd, by} : col_lb ? {4'd15, byi} : col_tl ? {4'd15, byd} : 8'd0;
    fra_rd_adr_o = fra_t ? {cx, bx} : fra_tr ? {(bx == 15 ? cxi : cx), bxi} :
                   fra_tl ? {(bx == 0 ? cxd : cx), bxd} : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else st <= nx;
  end
  // each segment lands one cycle after the state that issued its read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bx <= '0;
      by <= '0;
      cx <= '0;
      xf <= 1'b0;
      xl <= 1'b0;
      yf <= 1'b0;
      ref_top_o <= '0;
      ref_lft_o <= '0;
      ref_tl_o <= '0;
      avail_o <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= st == FIN;
      if (st == IDLE && start_i) begin
        bx <= blk_4x4_x_i;
        by <= blk_4x4_y_i;
        cx <= ctu_x_cur_i;
        xf <= ctu_x_first_i;
        xl <= ctu_x_last_i;
        yf <= ctu_y_first_i;
      end
      if (st == RD_TR) begin
        ref_top_o[PIXEL_WIDTH*8-1:PIXEL_WIDTH*4] <= av_t ? (by != 0 ? row_rd_dat_i : fra_rd_dat_i) : FILL;
        avail_o[3] <= av_t;
      end
      if (st == RD_L) begin
        ref_top_o[PIXEL_WIDTH*4-1:0] <= av_tr ? (by != 0 ? row_rd_dat_i : fra_rd_dat_i) : FILL;
        avail_o[2] <= av_tr;
      end
      if (st == RD_LB) begin
        ref_lft_o[PIXEL_WIDTH*8-1:PIXEL_WIDTH*4] <= av_l ? col_rd_dat_i : FILL;
        avail_o[1] <= av_l;
      end
      if (st == RD_TL) begin
        ref_lft_o[PIXEL_WIDTH*4-1:0] <= av_lb ? col_rd_dat_i : FILL;
        avail_o[0] <= av_lb;
      end
      if (st == FIN) begin
        ref_tl_o <= !av_tl ? FILL[PIXEL_WIDTH-1:0] :
                    by != 0 && bx != 0 ? row_rd_dat_i[PIXEL_WIDTH-1:0] :
                    by != 0 ? col_rd_dat_i[PIXEL_WIDTH-1:0] : fra_rd_dat_i[PIXEL_WIDTH-1:0];
        avail_o[4] <= av_tl;
      end
    end
  end
endmodule

// File: tb/tb_posi_fetch.sv
// tb_posi_fetch: random and directed neighbour fetches checked against a
// coordinate-based model of which neighbour blocks exist and where they are stored.
module tb_posi_fetch;
  localparam int PW = 8;
  localparam int PXW = 4;
  logic clk = 0, rst = 1, start_i = 0;
  logic [3:0] bx_i = 0, by_i = 0;
  logic [PXW-1:0] cx_i = 0;
  logic xf_i = 0, xl_i = 0, yf_i = 0;
  logic row_rd_ena_o, col_rd_ena_o, fra_rd_ena_o;
  logic [7:0] row_rd_adr_o, col_rd_adr_o;
  logic [PXW+3:0] fra_rd_adr_o;
  logic [PW*4-1:0] row_rd_dat_i = 0, col_rd_dat_i = 0, fra_rd_dat_i = 0;
  logic [PW*8-1:0] ref_top_o, ref_lft_o;
  logic [PW-1:0] ref_tl_o;
  logic [4:0] avail_o;
  logic done_o;
  logic [31:0] row_mem [256], col_mem [256], fra_mem [256];
  int tests = 0, fails = 0, nreads = 0;
  int m_cx, m_by;
  bit m_xf, m_xl, m_yf;

  posi_fetch #(.PIXEL_WIDTH(PW), .PIC_X_WIDTH(PXW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .blk_4x4_x_i(bx_i), .blk_4x4_y_i(by_i), .ctu_x_cur_i(cx_i),
    .ctu_x_first_i(xf_i), .ctu_x_last_i(xl_i), .ctu_y_first_i(yf_i),
    .row_rd_ena_o(row_rd_ena_o), .row_rd_adr_o(row_rd_adr_o), .row_rd_dat_i(row_rd_dat_i),
    .col_rd_ena_o(col_rd_ena_o), .col_rd_adr_o(col_rd_adr_o), .col_rd_dat_i(col_rd_dat_i),
    .fra_rd_ena_o(fra_rd_ena_o), .fra_rd_adr_o(fra_rd_adr_o), .fra_rd_dat_i(fra_rd_dat_i),
    .ref_top_o(ref_top_o), .ref_lft_o(ref_lft_o), .ref_tl_o(ref_tl_o),
    .avail_o(avail_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (row_rd_ena_o) row_rd_dat_i <= row_mem[row_rd_adr_o];
    if (col_rd_ena_o) col_rd_dat_i <= col_mem[col_rd_adr_o];
    if (fra_rd_ena_o) fra_rd_dat_i <= fra_mem[fra_rd_adr_o];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("one_read", {63'd0, $countones({row_rd_ena_o, col_rd_ena_o, fra_rd_ena_o}) <= 1}, 64'd1);
    nreads += $countones({row_rd_ena_o, col_rd_ena_o, fra_rd_ena_o});
  endtask

  // neighbour block at (nx,ny) relative to the current CTU; top_side picks the
  // bottom-row store for blocks inside the CTU, else the right-column store
  function automatic logic [31:0] nb(input int nx, input int ny, input bit top_side, output bit av);
    logic [31:0] w;
    w = 32'h80808080;
    av = 0;
    if (ny > 15) av = 0;
    else if (ny < 0) begin
      av = !m_yf && !(nx > 15 && m_xl) && !(nx < 0 && m_xf);
      w = fra_mem[8'((((m_cx + (nx > 15 ? 1 : 0) - (nx < 0 ? 1 : 0)) & 15) << 4) | (nx & 15))];
    end else if (nx < 0) begin
      av = !m_xf;
      w = col_mem[8'(8'hF0 | ny)];
    end else if (nx > 15) av = 0;
    else begin
      av = ny <= m_by;
      w = top_side ? row_mem[8'((ny << 4) | nx)] : col_mem[8'((nx << 4) | ny)];
    end
    return av ? w : 32'h80808080;
  endfunction

  task automatic fetch(input int x, input int y, input int c, input bit xf, input bit xl, input bit yf);
    logic [31:0] t, tr, l, lb, tlw;
    bit at, atr, al, alb, atl;
    m_cx = c; m_by = y; m_xf = xf; m_xl = xl; m_yf = yf;
    bx_i = 4'(x); by_i = 4'(y); cx_i = PXW'(c);
    xf_i = xf; xl_i = xl; yf_i = yf;
    start_i = 1;
    nreads = 0;
    step();
    start_i = 0;
    for (int i = 0; i < 6; i++) begin
      chk("done_early", {63'd0, done_o}, 64'd0);
      step();
    end
    chk("done_pulse", {63'd0, done_o}, 64'd1);
    t = nb(x, y - 1, 1, at);
    tr = nb(x + 1, y - 1, 1, atr);
    l = nb(x - 1, y, 0, al);
    lb = nb(x - 1, y + 1, 0, alb);
    tlw = nb(x - 1, y - 1, 1, atl);
    chk("ref_top", ref_top_o, {t, tr});
    chk("ref_lft", ref_lft_o, {l, lb});
    chk("ref_tl", 64'(ref_tl_o), 64'(tlw[7:0]));
    chk("avail", 64'(avail_o), 64'({atl, at, atr, al, alb}));
    chk("read_count", 64'(nreads), 64'(int'(at) + int'(atr) + int'(al) + int'(alb) + int'(atl)));
    step();
    chk("done_once", {63'd0, done_o}, 64'd0);
    chk("hold_top", ref_top_o, {t, tr});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      row_mem[i] = $urandom;
      col_mem[i] = $urandom;
      fra_mem[i] = $urandom;
    end
    #2;
    chk("rst_avail", 64'(avail_o), 64'd0);
    chk("rst_top", ref_top_o, 64'd0);
    chk("rst_ena", 64'({row_rd_ena_o, col_rd_ena_o, fra_rd_ena_o}), 64'd0);
    chk("rst_done", {63'd0, done_o}, 64'd0);
    @(posedge clk);
    #1 rst = 0;
    fetch(5, 3, 7, 0, 0, 0);
    chk("interior_avail", 64'(avail_o), 64'(5'b11110));
    chk("interior_lftb", 64'(ref_lft_o[31:0]), 64'h80808080);
    fetch(15, 0, 9, 0, 1, 0);
    chk("edge_topr", 64'(ref_top_o[31:0]), 64'h80808080);
    chk("edge_avail2", {63'd0, avail_o[2]}, 64'd0);
    fetch(0, 0, 0, 1, 0, 1);
    chk("corner_avail", 64'(avail_o), 64'd0);
    chk("corner_top", ref_top_o, {8{8'h80}});
    chk("corner_lft", ref_lft_o, {8{8'h80}});
    chk("corner_tl", 64'(ref_tl_o), 64'h80);
    fetch(0, 7, 3, 0, 0, 0);
    chk("left_col_tl", 64'(ref_tl_o), 64'(col_mem[8'hF6][7:0]));
    fetch(15, 0, 15, 0, 0, 0);
    fetch(0, 0, 0, 0, 0, 0);
    fetch(0, 15, 2, 0, 0, 1);
    for (int k = 0; k < 30; k++)
      fetch($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    // second start mid-fetch is ignored, reset in RD_TL aborts silently
    bx_i = 4'd5; by_i = 4'd3; cx_i = 4'd1; xf_i = 0; xl_i = 0; yf_i = 0;
    start_i = 1;
    step();
    start_i = 0;
    step();
    step();
    start_i = 1;
    step();
    start_i = 0;
    step();
    chk("abort_tl_read", {63'd0, row_rd_ena_o}, 64'd1);
    #2 rst = 1;
    #1;
    chk("abort_ena", 64'({row_rd_ena_o, col_rd_ena_o, fra_rd_ena_o}), 64'd0);
    chk("abort_adr", 64'({row_rd_adr_o, col_rd_adr_o, fra_rd_adr_o}), 64'd0);
    chk("abort_top", ref_top_o, 64'd0);
    chk("abort_lft", ref_lft_o, 64'd0);
    chk("abort_avail", 64'(avail_o), 64'd0);
    chk("abort_done", {63'd0, done_o}, 64'd0);
    @(negedge clk);
    rst = 0;
    nreads = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("abort_no_done", {63'd0, done_o}, 64'd0);
    end
    chk("abort_idle_reads", 64'(nreads), 64'd0);
    fetch(3, 9, 4, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
